// File: rtl/eth_ram_rd_arbiter_pkg.sv
// Shared types and defaults for the packet-RAM read-port arbiter.
// The default widths track the eth_writer RAM geometry.
package eth_ram_rd_arbiter_pkg;

  localparam int ETH_RAM_ADDR_W   = 16;
  localparam int ETH_RAM_DATA_MSB = 15;

  // Encodings 2 and 3 are never entered on purpose; the FSM recovers from them to IDLE.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1
  } arb_state_e;

  // One spare bit so that beat_cnt+1 can reach MAX_BURST without wrapping.
  function automatic int beat_cnt_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/eth_rr_pick.sv
// Round-robin picker: first set request at or after ptr+1 (mod NUM_REQ).
// Purely combinational; any=0 when no request is set.
module eth_rr_pick
  import eth_ram_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GNT_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GNT_W-1:0]   ptr,
  output logic [GNT_W-1:0]   pick,
  output logic               any
);

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        pick = GNT_W'((int'(ptr) + k) % NUM_REQ);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_ram_rd_arbiter.sv
// Round-robin arbiter for the single packet-RAM read port, with per-requester
// burst lock capped at MAX_BURST beats. Every release passes through one IDLE cycle.
module eth_ram_rd_arbiter
  import eth_ram_rd_arbiter_pkg::*;
#(
  parameter  int DATA_WIDTH_MSB = ETH_RAM_DATA_MSB,
  parameter  int ADDR_WIDTH     = ETH_RAM_ADDR_W,
  parameter  int NUM_REQ        = 2,
  parameter  int MAX_BURST      = 16,
  localparam int GNT_W          = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH_MSB:0]       req_rd_data,
  output logic                          ram_rd_valid,
  output logic [ADDR_WIDTH-1:0]         ram_rd_addr,
  input  logic                          ram_rd_ready,
  input  logic [DATA_WIDTH_MSB:0]       ram_rd_data,
  output logic [GNT_W-1:0]              grant_id,
  output logic [1:0]                    arb_state
);

  localparam int                BEAT_W    = beat_cnt_w(MAX_BURST);
  localparam logic [BEAT_W-1:0] BURST_LIM = BEAT_W'(MAX_BURST);
  localparam logic [GNT_W-1:0]  PTR_RST   = GNT_W'(NUM_REQ - 1);

  arb_state_e                           state_q, state_d;
  logic [GNT_W-1:0]                     grant_q, grant_d;
  logic [GNT_W-1:0]                     ptr_q, ptr_d;
  logic [BEAT_W-1:0]                    beat_q, beat_d, beat_inc;
  logic [GNT_W-1:0]                     pick;
  logic                                 any;
  logic                                 in_grant, g_valid, g_lock, beat;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_arr;

  assign addr_arr = req_addr;

  eth_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GNT_W   (GNT_W)
  ) u_pick (
    .req  (req_valid),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  assign in_grant = (state_q == ARB_GRANT);
  assign g_valid  = req_valid[grant_q];
  assign g_lock   = req_lock[grant_q];
  assign beat_inc = beat_q + 1'b1;

  // A withdrawn request drops the RAM request immediately, so a stray ram_rd_ready is ignored.
  assign ram_rd_valid = in_grant & g_valid;
  assign ram_rd_addr  = ram_rd_valid ? addr_arr[grant_q] : '0;
  assign beat         = ram_rd_valid & ram_rd_ready;
  assign req_rd_data  = in_grant ? ram_rd_data : '0;
  assign grant_id     = grant_q;
  assign arb_state    = state_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign req_ready[i] = beat & (grant_q == GNT_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    case (state_q)
      ARB_IDLE: begin
        if (any) begin
          grant_d = pick;
          ptr_d   = pick;
          beat_d  = '0;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (!g_valid) begin
          state_d = ARB_IDLE;
        end else if (beat) begin
          beat_d = beat_inc;
          if (!(g_lock && (beat_inc < BURST_LIM))) state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule
